pe_feeder: RTL and testbench

Sequencing front end for one processing element: walks the image and filter scratchpads, streams pixel/filter pairs into the PE's MAC, and issues every PE control strobe (accumulator clear, accumulate, result-buffer capture, result-memory write, file dump). It is the initiator for the PE's control/data port. One feeder drives one PE. Its outputs connect 1:1 to the PE inputs of the same name.

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe_feed_adr_gen.sv | 87 ++++++++
 rtl/pe_feeder.sv | 125 ++++++++++++
 tb/tb_pe_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the PE feeder: FSM state encoding, address width,
// and the effective-filter-count rule applied when a job is accepted.
package pe_pkg;

    localparam int ADR_W       = 8;
    localparam int NUM_RES_DEF = 4;

    typedef enum logic [3:0] {
        IDLE,
        CLR,
        FEED,
        DRAIN,
        STORE,
        WRITE,
        RES_CLR,
        DUMP,
        DONE
    } state_t;

    // Zero filters still produces one result per window; larger requests clamp to the buffer depth.
    function automatic logic [2:0] eff_filters(input logic [2:0] nf, input logic [2:0] cap);
        if (nf == 3'd0) begin
            return 3'd1;
        end else if (nf > cap) begin
            return cap;
        end else begin
            return nf;
        end
    endfunction

endpackage

// File: rtl/pe_feed_adr_gen.sv
// Window/filter/element counters and scratchpad address generation for the PE feeder.
// Bases are advanced incrementally so no multiplier is needed for w*stride or f*FILTER_SIZE.
module pe_feed_adr_gen
    import pe_pkg::*;
#(
    parameter int FILTER_SIZE = 16,
    parameter int NUM_RES     = NUM_RES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [ADR_W-1:0] i_img_base,
    input  logic [ADR_W-1:0] i_stride,
    input  logic [7:0]       i_num_windows,
    input  logic [2:0]       i_num_filters,
    input  logic             i_clr_k,
    input  logic             i_inc_k,
    input  logic             i_next_filter,
    input  logic             i_next_window,
    output logic [ADR_W-1:0] o_img_adr,
    output logic [ADR_W-1:0] o_filt_adr,
    output logic [7:0]       o_w,
    output logic [7:0]       o_f,
    output logic             o_last_k,
    output logic             o_last_f,
    output logic             o_last_w
);

    localparam logic [6:0]       K_LAST  = 7'(FILTER_SIZE - 1);
    localparam logic [ADR_W-1:0] FS_STEP = ADR_W'(FILTER_SIZE);
    localparam logic [2:0]       NF_CAP  = 3'(NUM_RES);

    logic [ADR_W-1:0] r_stride;
    logic [7:0]       r_num_windows;
    logic [2:0]       r_nf;
    logic [ADR_W-1:0] r_win_base;
    logic [ADR_W-1:0] r_filt_base;
    logic [7:0]       r_w;
    logic [2:0]       r_f;
    logic [6:0]       r_k;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stride      <= '0;
            r_num_windows <= '0;
            r_nf          <= 3'd1;
            r_win_base    <= '0;
            r_filt_base   <= '0;
            r_w           <= '0;
            r_f           <= '0;
            r_k           <= '0;
        end else if (i_load) begin
            r_stride      <= i_stride;
            r_num_windows <= i_num_windows;
            r_nf          <= eff_filters(i_num_filters, NF_CAP);
            r_win_base    <= i_img_base;
            r_filt_base   <= '0;
            r_w           <= '0;
            r_f           <= '0;
            r_k           <= '0;
        end else begin
            if (i_clr_k) begin
                r_k <= '0;
            end else if (i_inc_k) begin
                r_k <= r_k + 7'd1;
            end
            if (i_next_window) begin
                r_w         <= r_w + 8'd1;
                r_win_base  <= r_win_base + r_stride;
                r_f         <= '0;
                r_filt_base <= '0;
            end else if (i_next_filter) begin
                r_f         <= r_f + 3'd1;
                r_filt_base <= r_filt_base + FS_STEP;
            end
        end
    end

    assign o_img_adr  = r_win_base + {1'b0, r_k};
    assign o_filt_adr = r_filt_base + {1'b0, r_k};
    assign o_w        = r_w;
    assign o_f        = {5'd0, r_f};
    assign o_last_k   = (r_k == K_LAST);
    assign o_last_f   = (r_f == r_nf - 3'd1);
    assign o_last_w   = (r_w == r_num_windows - 8'd1);

endmodule

// File: rtl/pe_feeder.sv
// Sequencing front end for one PE: FSM walking windows/filters, read-enable to acc_en
// alignment, and decode of every PE control strobe from the current state.
module pe_feeder
    import pe_pkg::*;
#(
    parameter int FILTER_SIZE = 16,
    parameter int MAC_LAT     = 1,
    parameter int NUM_RES     = NUM_RES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] img_base,
    input  logic [ADR_W-1:0] stride,
    input  logic [7:0]       num_windows,
    input  logic [2:0]       num_filters,
    output logic             busy,
    output logic             done,
    output logic             img_rd_en,
    output logic [ADR_W-1:0] img_rd_adr,
    input  logic [7:0]       img_rd_data,
    output logic             filt_rd_en,
    output logic [ADR_W-1:0] filt_rd_adr,
    input  logic [7:0]       filt_rd_data,
    output logic [7:0]       img_pixel,
    output logic [7:0]       filter_value,
    output logic             rst_acc,
    output logic             acc_en,
    output logic             res_buffer_en,
    output logic [7:0]       res_index,
    output logic             rst_res_reg,
    output logic             wr_en,
    output logic [ADR_W-1:0] wr_adr,
    output logic             wr_file
);

    localparam logic [7:0] DRAIN_LAST = 8'(MAC_LAT);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_drain_cnt;
    logic             r_acc_en;

    logic             w_load;
    logic [ADR_W-1:0] w_img_adr;
    logic [ADR_W-1:0] w_filt_adr;
    logic [7:0]       w_w;
    logic [7:0]       w_f;
    logic             w_last_k;
    logic             w_last_f;
    logic             w_last_w;

    assign w_load = (r_state == IDLE) && start;

    pe_feed_adr_gen #(
        .FILTER_SIZE(FILTER_SIZE),
        .NUM_RES    (NUM_RES)
    ) u_adr_gen (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_img_base   (img_base),
        .i_stride     (stride),
        .i_num_windows(num_windows),
        .i_num_filters(num_filters),
        .i_clr_k      (r_state == CLR),
        .i_inc_k      (r_state == FEED),
        .i_next_filter((r_state == STORE) && !w_last_f),
        .i_next_window((r_state == RES_CLR) && !w_last_w),
        .o_img_adr    (w_img_adr),
        .o_filt_adr   (w_filt_adr),
        .o_w          (w_w),
        .o_f          (w_f),
        .o_last_k     (w_last_k),
        .o_last_f     (w_last_f),
        .o_last_w     (w_last_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_drain_cnt <= '0;
            r_acc_en    <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_drain_cnt <= (r_state == DRAIN) ? r_drain_cnt + 8'd1 : 8'd0;
            // Read data returns one cycle after the enable, so accumulate lags FEED by one.
            r_acc_en    <= (r_state == FEED);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (num_windows == 8'd0) ? DUMP : CLR;
            CLR:     w_next = FEED;
            FEED:    if (w_last_k) w_next = DRAIN;
            DRAIN:   if (r_drain_cnt == DRAIN_LAST) w_next = STORE;
            STORE:   w_next = w_last_f ? WRITE : CLR;
            WRITE:   w_next = RES_CLR;
            RES_CLR: w_next = w_last_w ? DUMP : CLR;
            DUMP:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign busy          = (r_state != IDLE);
    assign done          = (r_state == DONE);
    assign img_rd_en     = (r_state == FEED);
    assign filt_rd_en    = (r_state == FEED);
    assign img_rd_adr    = img_rd_en ? w_img_adr : '0;
    assign filt_rd_adr   = filt_rd_en ? w_filt_adr : '0;
    assign img_pixel     = img_rd_data;
    assign filter_value  = filt_rd_data;
    assign rst_acc       = (r_state == CLR);
    assign acc_en        = r_acc_en;
    assign res_buffer_en = (r_state == STORE);
    assign res_index     = res_buffer_en ? w_f : '0;
    assign rst_res_reg   = (r_state == RES_CLR);
    assign wr_en         = (r_state == WRITE);
    assign wr_adr        = wr_en ? w_w : '0;
    assign wr_file       = (r_state == DUMP);

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder: per-cycle comparison of every strobe/address against a
// timeline built from nested window/filter/element loops, plus hand-computed checkpoints.
module tb_pe_feeder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] img_base = 8'd0;
    logic [7:0] stride = 8'd0;
    logic [7:0] num_windows = 8'd0;
    logic [2:0] num_filters = 3'd0;
    logic       busy, done, img_rd_en, filt_rd_en;
    logic [7:0] img_rd_adr, filt_rd_adr, img_rd_data, filt_rd_data;
    logic [7:0] img_pixel, filter_value, res_index, wr_adr;
    logic       rst_acc, acc_en, res_buffer_en, rst_res_reg, wr_en, wr_file;

    always #5 clk = ~clk;

    pe_feeder #(.FILTER_SIZE(16), .MAC_LAT(1), .NUM_RES(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .img_base(img_base), .stride(stride),
        .num_windows(num_windows), .num_filters(num_filters),
        .busy(busy), .done(done),
        .img_rd_en(img_rd_en), .img_rd_adr(img_rd_adr), .img_rd_data(img_rd_data),
        .filt_rd_en(filt_rd_en), .filt_rd_adr(filt_rd_adr), .filt_rd_data(filt_rd_data),
        .img_pixel(img_pixel), .filter_value(filter_value),
        .rst_acc(rst_acc), .acc_en(acc_en),
        .res_buffer_en(res_buffer_en), .res_index(res_index),
        .rst_res_reg(rst_res_reg), .wr_en(wr_en), .wr_adr(wr_adr), .wr_file(wr_file)
    );

    // Scratchpad models: synchronous read, contents are a fixed function of the address.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            img_rd_data  <= 8'd0;
            filt_rd_data <= 8'd0;
        end else begin
            if (img_rd_en)  img_rd_data  <= img_rd_adr ^ 8'h5A;
            if (filt_rd_en) filt_rd_data <= filt_rd_adr + 8'd3;
        end
    end

    int          total = 0;
    int          bad   = 0;
    logic [41:0] exp_q[$];
    logic [15:0] pix_q[$];
    logic        prev_rd;
    logic [7:0]  prev_ia, prev_fa;

    function automatic logic [41:0] obs_vec();
        return {busy, done, img_rd_en, img_rd_adr, filt_rd_en, filt_rd_adr, rst_acc, acc_en,
                res_buffer_en, res_index, rst_res_reg, wr_en, wr_adr, wr_file};
    endfunction

    task automatic push(input logic b, input logic d, input logic rd, input logic [7:0] ia,
                        input logic [7:0] fa, input logic ra, input logic re, input logic [7:0] ri,
                        input logic rr, input logic we, input logic [7:0] wa, input logic wf);
        exp_q.push_back({b, d, rd, ia, rd, fa, ra, prev_rd, re, ri, rr, we, wa, wf});
        pix_q.push_back({prev_ia ^ 8'h5A, prev_fa + 8'd3});
        prev_rd = rd;
        prev_ia = ia;
        prev_fa = fa;
    endtask

    task automatic build(input logic [7:0] base, input logic [7:0] strd, input int nw, input int nf);
        exp_q.delete();
        pix_q.delete();
        prev_rd = 1'b0;
        prev_ia = 8'd0;
        prev_fa = 8'd0;
        for (int w = 0; w < nw; w++) begin
            for (int f = 0; f < nf; f++) begin
                push(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
                for (int k = 0; k < 16; k++)
                    push(1, 0, 1, 8'(int'(base) + w * int'(strd) + k), 8'(f * 16 + k),
                         0, 0, 0, 0, 0, 0, 0);
                push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push(1, 0, 0, 0, 0, 0, 1, 8'(f), 0, 0, 0, 0);
            end
            push(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8'(w), 0);
            push(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        end
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        push(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Start is driven before edge 0; the negedge after edge n samples cycle n+1.
    task automatic run_job(input string name, input logic [7:0] base, input logic [7:0] strd,
                           input logic [7:0] nw, input logic [2:0] nf_in, input int nf_model,
                           input int done_exp, input int inj_cyc, input int chk_cyc,
                           input logic [7:0] chk_adr);
        int done_cyc;
        logic [41:0] ov;
        build(base, strd, int'(nw), nf_model);
        done_cyc = -1;
        @(negedge clk);
        img_base = base; stride = strd; num_windows = nw; num_filters = nf_in; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= exp_q.size(); c++) begin
            start = 1'b0;
            ov = obs_vec();
            total++;
            assert (ov === exp_q[c-1]) else begin
                bad++;
                $error("FAIL %s cyc=%0d obs=%h exp=%h", name, c, ov, exp_q[c-1]);
            end
            if (exp_q[c-1][14]) begin
                total++;
                assert ({img_pixel, filter_value} === pix_q[c-1]) else begin
                    bad++;
                    $error("FAIL %s_data cyc=%0d obs=%h exp=%h", name, c,
                           {img_pixel, filter_value}, pix_q[c-1]);
                end
            end
            if (c == chk_cyc) begin
                total++;
                assert (img_rd_adr === chk_adr) else begin
                    bad++;
                    $error("FAIL %s_adr cyc=%0d obs=%h exp=%h", name, c, img_rd_adr, chk_adr);
                end
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (c == inj_cyc) begin
                img_base = 8'hEE; stride = 8'h11; num_windows = 8'd5; num_filters = 3'd2;
                start = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        total++;
        assert (done_cyc === done_exp) else begin
            bad++;
            $error("FAIL %s_done obs=%0d exp=%0d", name, done_cyc, done_exp);
        end
        $display("job %s: done at cycle %0d", name, done_cyc);
    endtask

    initial begin
        logic [41:0] ov;
        logic [5:0]  strobes;
        // Reset state
        #2;
        ov = obs_vec();
        total++;
        assert (ov === 42'd0) else begin
            bad++;
            $error("FAIL reset_state obs=%h exp=%h", ov, 42'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_job("default", 8'd8, 8'd4, 8'd1, 3'd1, 1, 24, 0, 2, 8'd8);
        run_job("multi", 8'd8, 8'd2, 8'd3, 3'd4, 4, 248, 248, 166, 8'd12);
        run_job("nw0", 8'd8, 8'd4, 8'd0, 3'd1, 1, 2, 0, 1, 8'd0);
        run_job("nf0", 8'd20, 8'd16, 8'd2, 3'd0, 1, 46, 0, 24, 8'd36);
        run_job("nf7", 8'd0, 8'd1, 8'd1, 3'd7, 4, 84, 0, 62, 8'd0);
        run_job("wrap", 8'd250, 8'd0, 8'd1, 3'd1, 1, 24, 5, 8, 8'd0);

        // Reset mid-FEED: start, run into FEED, hold reset 3 cycles, then watch for stray strobes
        @(negedge clk);
        img_base = 8'd8; stride = 8'd4; num_windows = 8'd2; num_filters = 3'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            ov = obs_vec();
            total++;
            assert (ov === 42'd0) else begin
                bad++;
                $error("FAIL rst_hold cyc=%0d obs=%h exp=%h", i, ov, 42'd0);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            strobes = {busy, acc_en, wr_en, res_buffer_en, wr_file, done};
            total++;
            assert (strobes === 6'd0) else begin
                bad++;
                $error("FAIL post_rst cyc=%0d obs=%b exp=%b", i, strobes, 6'd0);
            end
        end
        run_job("after_rst", 8'd100, 8'd3, 8'd1, 3'd1, 1, 24, 0, 17, 8'd115);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
